// File: rtl/span_pkg.sv
// Shared types, constants and helpers for the span position loader.
// Ports: none (package). Provides position/maturity/TSC types, the loader
// state enum, signed saturating add and a slot-valid population count.
package span_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int POS_W     = 16;
  localparam int MAT_W     = 8;
  localparam int TSC_W     = 16;
  localparam int IDX_W     = $clog2(NUM_SLOTS);
  localparam int SLOTS_W   = $clog2(NUM_SLOTS + 1);

  typedef logic signed [POS_W-1:0] position_t;
  typedef logic [MAT_W-1:0]        maturity_t;
  typedef logic [TSC_W-1:0]        tsc_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [SLOTS_W-1:0]      slots_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } loader_state_e;

  // Signed add clamped to the most positive / most negative position value.
  function automatic position_t sat_add_pos(position_t a, position_t b);
    logic signed [POS_W:0] sum;
    position_t             r;
    sum = {a[POS_W-1], a} + {b[POS_W-1], b};
    // The two top bits disagree only when the true sum left the POS_W range.
    if (sum[POS_W] != sum[POS_W-1]) begin
      r            = '0;
      r[POS_W-1]   = sum[POS_W];
      r[POS_W-2:0] = {(POS_W-1){~sum[POS_W]}};
    end else begin
      r = sum[POS_W-1:0];
    end
    return r;
  endfunction

  function automatic slots_t popcount_slots(logic [NUM_SLOTS-1:0] v);
    slots_t c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + slots_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/span_position_loader_if.sv
// Handshake bundles for the span position loader.
// span_rec_if: position record stream (master = record producer, slave = loader).
// span_res_if: TSC result stream (master = loader, slave = result consumer).
interface span_rec_if
  import span_pkg::*;
  ();
  logic      rec_valid;
  logic      rec_ready;
  maturity_t rec_maturity;
  position_t rec_qty;
  logic      rec_last;

  modport master (
    output rec_valid, rec_maturity, rec_qty, rec_last,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_maturity, rec_qty, rec_last,
    output rec_ready
  );
endinterface

interface span_res_if
  import span_pkg::*;
  ();
  logic   res_valid;
  logic   res_ready;
  tsc_t   res_tsc;
  slots_t res_slots;
  logic   res_overflow;

  modport master (
    output res_valid, res_tsc, res_slots, res_overflow,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_tsc, res_slots, res_overflow,
    output res_ready
  );
endinterface

// File: rtl/span_slot_cam.sv
// Combinational match/allocate lookup over the position table.
// Ports: slot_valid/slot_mat = current table, key = incoming maturity;
// hit/hit_idx = occupied slot with equal maturity, free/free_idx = lowest empty slot.
module span_slot_cam
  import span_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] slot_valid,
  input  maturity_t            slot_mat [NUM_SLOTS],
  input  maturity_t            key,
  output logic                 hit,
  output idx_t                 hit_idx,
  output logic                 free,
  output idx_t                 free_idx
);

  // Scan from the top down so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_valid[i] && (slot_mat[i] == key)) begin
        hit     = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (!slot_valid[i]) begin
        free     = 1'b1;
        free_idx = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/span_position_loader.sv
// Nets a record stream by maturity into a slot table feeding the spread
// calculator, resets the calculator per portfolio and captures its TSC.
// Ports: clk/reset (async active-high), rec (record stream in), position/maturity
// (table to calculator), calc_rst_n, tsc_in (calculator TSC), res (result stream out).
module span_position_loader
  import span_pkg::*;
#(
  parameter int SETTLE_CYCLES = 12
) (
  input  logic      clk,
  input  logic      reset,
  span_rec_if.slave rec,
  output position_t position [NUM_SLOTS],
  output maturity_t maturity [NUM_SLOTS],
  output logic      calc_rst_n,
  input  tsc_t      tsc_in,
  span_res_if.master res
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  loader_state_e        state, state_next;
  logic                 rec_ready;
  logic                 accept;

  logic [NUM_SLOTS-1:0] slot_valid;
  position_t            pos_q [NUM_SLOTS];
  maturity_t            mat_q [NUM_SLOTS];
  logic                 ovf_flag;
  logic [CNT_W-1:0]     settle_cnt;

  logic                 res_valid_q;
  tsc_t                 res_tsc_q;
  slots_t               res_slots_q;
  logic                 res_overflow_q;

  logic                 hit, free;
  idx_t                 hit_idx, free_idx;

  assign accept = rec.rec_valid && rec_ready;

  span_slot_cam u_cam (
    .slot_valid (slot_valid),
    .slot_mat   (mat_q),
    .key        (rec.rec_maturity),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .free       (free),
    .free_idx   (free_idx)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, LOAD: if (accept) state_next = rec.rec_last ? SETTLE : LOAD;
      SETTLE:     if (settle_cnt == '0) state_next = DONE;
      DONE:       if (res.res_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rec_ready = 1'b0;
    case (state)
      IDLE, LOAD: rec_ready = 1'b1;
      default:    rec_ready = 1'b0;
    endcase
  end

  assign rec.rec_ready = rec_ready;

  // Slot table. The first record of a portfolio wipes the table and lands in
  // slot 0; later records net into a matching slot, allocate, or are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      ovf_flag   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_q[i] <= '0;
        mat_q[i] <= '0;
      end
    end else if (accept) begin
      if (state == IDLE) begin
        slot_valid <= NUM_SLOTS'(1);
        ovf_flag   <= 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          pos_q[i] <= '0;
          mat_q[i] <= '0;
        end
        pos_q[0] <= rec.rec_qty;
        mat_q[0] <= rec.rec_maturity;
      end else if (hit) begin
        pos_q[hit_idx] <= sat_add_pos(pos_q[hit_idx], rec.rec_qty);
      end else if (free) begin
        slot_valid[free_idx] <= 1'b1;
        pos_q[free_idx]      <= rec.rec_qty;
        mat_q[free_idx]      <= rec.rec_maturity;
      end else begin
        ovf_flag <= 1'b1;
      end
    end
  end

  // Settle counter: loaded on the last-record edge, then decremented once per
  // SETTLE cycle; the capture happens on the SETTLE edge that sees zero, which
  // puts res_valid SETTLE_CYCLES+1 edges after the last accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (accept && rec.rec_last) begin
      settle_cnt <= CNT_W'(SETTLE_CYCLES);
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Result register, held stable through DONE until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q    <= 1'b0;
      res_tsc_q      <= '0;
      res_slots_q    <= '0;
      res_overflow_q <= 1'b0;
    end else if ((state == SETTLE) && (settle_cnt == '0)) begin
      res_valid_q    <= 1'b1;
      res_tsc_q      <= tsc_in;
      res_slots_q    <= popcount_slots(slot_valid);
      res_overflow_q <= ovf_flag;
    end else if ((state == DONE) && res.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res.res_valid    = res_valid_q;
  assign res.res_tsc      = res_tsc_q;
  assign res.res_slots    = res_slots_q;
  assign res.res_overflow = res_overflow_q;

  // Calculator reset: low during our reset, and for the one cycle following
  // the edge that starts a new portfolio.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) calc_rst_n <= 1'b0;
    else       calc_rst_n <= !((state == IDLE) && accept);
  end

  // Empty slots present zeros regardless of stale register contents.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      position[i] = slot_valid[i] ? pos_q[i] : '0;
      maturity[i] = slot_valid[i] ? mat_q[i] : '0;
    end
  end

endmodule

// File: tb/tb_span_position_loader.sv
// Directed bench for span_position_loader: netting, overflow, saturation,
// result handshake, calculator reset pulse and mid-portfolio reset.
module tb_span_position_loader;
  import span_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  position_t position [NUM_SLOTS];
  maturity_t maturity [NUM_SLOTS];
  logic      calc_rst_n;
  tsc_t      tsc_in;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  span_rec_if rec_bus ();
  span_res_if res_bus ();

  span_position_loader #(.SETTLE_CYCLES(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .rec        (rec_bus),
    .position   (position),
    .maturity   (maturity),
    .calc_rst_n (calc_rst_n),
    .tsc_in     (tsc_in),
    .res        (res_bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one record and hold it until accepted; returns #1 after the accept edge.
  task automatic send_rec(input maturity_t m, input logic [15:0] q, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    rec_bus.rec_valid    = 1'b1;
    rec_bus.rec_maturity = m;
    rec_bus.rec_qty      = q;
    rec_bus.rec_last     = l;
    while (rec_bus.rec_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("rec_ready_timeout", {15'b0, rec_bus.rec_ready}, 16'd1);
    @(posedge clk);
    #1;
    rec_bus.rec_valid = 1'b0;
    rec_bus.rec_last  = 1'b0;
  endtask

  // Count edges from the last accept until res_valid rises.
  task automatic wait_res(input logic [15:0] exp_edges);
    int n;
    n = 0;
    while (res_bus.res_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("res_latency", 16'(n), exp_edges);
  endtask

  task automatic consume();
    @(negedge clk);
    res_bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("consume_res_valid", {15'b0, res_bus.res_valid}, 16'd0);
    check("consume_rec_ready", {15'b0, rec_bus.rec_ready}, 16'd1);
    res_bus.res_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    reset                = 1'b1;
    rec_bus.rec_valid    = 1'b0;
    rec_bus.rec_maturity = '0;
    rec_bus.rec_qty      = '0;
    rec_bus.rec_last     = 1'b0;
    res_bus.res_ready    = 1'b0;
    tsc_in               = 16'h0123;

    // Reset state
    #12;
    check("rst_res_valid", {15'b0, res_bus.res_valid}, 16'd0);
    check("rst_res_tsc", res_bus.res_tsc, 16'h0000);
    check("rst_res_slots", {12'b0, res_bus.res_slots}, 16'd0);
    check("rst_res_ovf", {15'b0, res_bus.res_overflow}, 16'd0);
    check("rst_calc_rst_n", {15'b0, calc_rst_n}, 16'd0);
    check("rst_rec_ready", {15'b0, rec_bus.rec_ready}, 16'd1);
    check("rst_pos0", position[0], 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("calc_rst_n_release", {15'b0, calc_rst_n}, 16'd1);

    // Netting: (3,+5),(7,-4),(3,+2,last)
    send_rec(8'd3, 16'd5, 1'b0);
    check("t1_calc_rst_low", {15'b0, calc_rst_n}, 16'd0);
    check("t1_pos0_first", position[0], 16'd5);
    send_rec(8'd7, 16'hFFFC, 1'b0);
    check("t1_calc_rst_back", {15'b0, calc_rst_n}, 16'd1);
    send_rec(8'd3, 16'd2, 1'b1);
    check("t1_rec_ready_settle", {15'b0, rec_bus.rec_ready}, 16'd0);
    wait_res(16'd13);
    tsc_in = 16'hBEEF;
    check("t1_pos0", position[0], 16'd7);
    check("t1_mat0", {8'b0, maturity[0]}, 16'd3);
    check("t1_pos1", position[1], 16'hFFFC);
    check("t1_mat1", {8'b0, maturity[1]}, 16'd7);
    check("t1_pos2", position[2], 16'd0);
    check("t1_mat2", {8'b0, maturity[2]}, 16'd0);
    check("t1_slots", {12'b0, res_bus.res_slots}, 16'd2);
    check("t1_ovf", {15'b0, res_bus.res_overflow}, 16'd0);
    check("t1_tsc", res_bus.res_tsc, 16'h0123);
    // Result held while the consumer stalls
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_res_valid", {15'b0, res_bus.res_valid}, 16'd1);
      check("hold_res_tsc", res_bus.res_tsc, 16'h0123);
      check("hold_rec_ready", {15'b0, rec_bus.rec_ready}, 16'd0);
    end
    consume();

    // Overflow: maturities 1..9, +1 each, last on 9; also checks table wipe
    tsc_in = 16'h0042;
    send_rec(8'd1, 16'd1, 1'b0);
    check("t2_calc_rst_low", {15'b0, calc_rst_n}, 16'd0);
    check("t2_cleared_pos1", position[1], 16'd0);
    check("t2_cleared_mat1", {8'b0, maturity[1]}, 16'd0);
    @(posedge clk);
    #1;
    check("t2_calc_rst_one_cycle", {15'b0, calc_rst_n}, 16'd1);
    for (int m = 2; m <= 9; m++) send_rec(maturity_t'(m), 16'd1, (m == 9));
    wait_res(16'd13);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      check("t2_mat", {8'b0, maturity[i]}, 16'(i + 1));
      check("t2_pos", position[i], 16'd1);
    end
    check("t2_slots", {12'b0, res_bus.res_slots}, 16'd8);
    check("t2_ovf", {15'b0, res_bus.res_overflow}, 16'd1);
    check("t2_tsc", res_bus.res_tsc, 16'h0042);
    consume();

    // Positive saturation
    send_rec(8'd2, 16'h7FF0, 1'b0);
    send_rec(8'd2, 16'h0100, 1'b1);
    wait_res(16'd13);
    check("sat_pos", position[0], 16'h7FFF);
    check("sat_pos_slots", {12'b0, res_bus.res_slots}, 16'd1);
    check("sat_pos_ovf", {15'b0, res_bus.res_overflow}, 16'd0);
    consume();

    // Negative saturation
    send_rec(8'd2, 16'h8005, 1'b0);
    send_rec(8'd2, 16'hFFF0, 1'b1);
    wait_res(16'd13);
    check("sat_neg", position[0], 16'h8000);
    consume();

    // Zero net keeps the slot; zero-quantity record still allocates
    send_rec(8'd8, 16'd3, 1'b0);
    send_rec(8'd8, 16'hFFFD, 1'b0);
    send_rec(8'd9, 16'd0, 1'b1);
    wait_res(16'd13);
    check("zero_pos0", position[0], 16'd0);
    check("zero_mat0", {8'b0, maturity[0]}, 16'd8);
    check("zero_mat1", {8'b0, maturity[1]}, 16'd9);
    check("zero_slots", {12'b0, res_bus.res_slots}, 16'd2);
    consume();

    // Reset three cycles into SETTLE
    send_rec(8'd4, 16'd1, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_res_valid", {15'b0, res_bus.res_valid}, 16'd0);
    check("mid_rst_rec_ready", {15'b0, rec_bus.rec_ready}, 16'd1);
    check("mid_rst_calc_rst_n", {15'b0, calc_rst_n}, 16'd0);
    check("mid_rst_pos0", position[0], 16'd0);
    check("mid_rst_mat0", {8'b0, maturity[0]}, 16'd0);
    check("mid_rst_slots", {12'b0, res_bus.res_slots}, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (res_bus.res_valid === 1'b1) seen = 1'b1;
    end
    check("mid_rst_no_result", {15'b0, seen}, 16'd0);
    send_rec(8'd5, 16'd1, 1'b1);
    wait_res(16'd13);
    check("post_rst_slots", {12'b0, res_bus.res_slots}, 16'd1);
    check("post_rst_mat0", {8'b0, maturity[0]}, 16'd5);
    check("post_rst_ovf", {15'b0, res_bus.res_overflow}, 16'd0);
    consume();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/span_position_loader.md
Name: span_position_loader

Overview:
- Front-end producer for the intermonth spread calculator.
- Accepts a valid/ready stream of per-contract position records (maturity, signed quantity), nets records by maturity into an 8-slot table, and drives that table onto the calculator's position/maturity array inputs.
- Pulses the calculator's active-low reset at each new portfolio, waits a fixed settle time, then captures the calculator's TSC into a result register under a valid/ready handshake.

Parameters:
- NUM_SLOTS, 8, table entries; equals calculator array depth.
- POS_W, 16, signed position width (two's complement).
- MAT_W, 8, maturity code width.
- TSC_W, 16, total spread charge width.
- SETTLE_CYCLES, 12, cycles between final table update and TSC capture; must cover calculator pipeline depth.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rec_valid  in  1  record valid.
- rec_ready  out  1  record accepted when rec_valid && rec_ready.
- rec_maturity  in  MAT_W  record maturity code.
- rec_qty  in  POS_W  signed record quantity.
- rec_last  in  1  final record of portfolio.
- position  out  POS_W x NUM_SLOTS  netted positions to calculator.
- maturity  out  MAT_W x NUM_SLOTS  slot maturities to calculator.
- calc_rst_n  out  1  active-low reset to calculator.
- tsc_in  in  TSC_W  TSC from calculator.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_tsc  out  TSC_W  captured TSC.
- res_slots  out  4  number of occupied slots (0..8).
- res_overflow  out  1  at least one record was dropped because the table was full.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; all position/maturity/slot-valid cleared; res_valid=0, res_tsc=0, res_slots=0, res_overflow=0; calc_rst_n=0.
  - calc_rst_n returns to 1 on the first clock edge after reset deasserts.
- FSM states: IDLE, LOAD, SETTLE, DONE.
  - rec_ready=1 in IDLE and LOAD, otherwise 0.
  - IDLE, on accept: clear table and overflow flag, write the record into slot 0, drive calc_rst_n=0 for exactly that next cycle. Go to SETTLE if rec_last, else LOAD.
  - LOAD, on accept, first matching rule wins:
    - maturity equals an occupied slot's maturity: add rec_qty to that slot with signed saturation to 0x7FFF/0x8000.
    - else a free slot exists: write into the lowest free slot.
    - else: drop the record and set the overflow flag.
    - Then go to SETTLE if rec_last, else stay in LOAD.
  - SETTLE: a down-counter loaded with SETTLE_CYCLES counts down to 0. Exit to DONE on the edge where it reaches 0. On that same edge: res_tsc<=tsc_in, res_slots<=popcount(slot-valid), res_overflow<=flag, res_valid<=1.
  - DONE: hold res_valid and all res_* stable until res_ready, then res_valid<=0 and go to IDLE. Table contents persist until the next portfolio's first record.
- Latency: table outputs update on the edge that accepts a record. res_valid rises exactly SETTLE_CYCLES+1 edges after the edge accepting the rec_last record.
- Table rules:
  - Unoccupied slots drive position=0, maturity=0.
  - Matching compares only occupied slots.
  - A zero-quantity record still allocates a slot when unmatched.
  - A netted sum of 0 keeps the slot occupied.
- rec_last on a dropped (overflow) record still ends the portfolio.
- rec_valid in SETTLE/DONE is ignored (not accepted) and must hold per valid/ready rules.
- Reset asserted mid-LOAD/SETTLE/DONE: immediate return to reset values; a partial portfolio is discarded and no result is produced.

Decomposition:
- Shared package span_pkg holds:
  - constants NUM_SLOTS, POS_W, MAT_W, TSC_W;
  - typedef position_t (signed POS_W), maturity_t, tsc_t;
  - enum loader_state_e {IDLE, LOAD, SETTLE, DONE};
  - function sat_add_pos(position_t, position_t).
- One sub-module, span_slot_cam: combinational match/allocate over the slot-valid and maturity arrays. It outputs hit, hit_idx, free, and free_idx (lowest free).

Test Plan:
- Records (m=3,+5),(m=7,-4),(m=3,+2,last) -> slot0={3,+7}, slot1={7,-4}, others 0. res_slots=2, res_overflow=0, res_valid at last-accept+13 edges.
- Nine distinct maturities 1..9 qty +1, last on ninth -> slots hold maturities 1..8. res_slots=8, res_overflow=1; maturity 9 absent.
- Records (m=2,0x7FF0),(m=2,0x0100,last) -> slot0 position=0x7FFF. Then (m=2,0x8005),(m=2,-16,last) -> 0x8000.
- tsc_in driven 0x0123 during SETTLE with res_ready held 0 for 5 cycles after res_valid -> res_tsc=0x0123 stable, rec_ready=0. Asserting res_ready returns the FSM to IDLE and rec_ready=1.
- New portfolio after DONE -> calc_rst_n low exactly one cycle after the first accept, and the previous table is cleared.
- reset pulsed 3 cycles into SETTLE -> all outputs return to reset values asynchronously. No res_valid follows; the next single record (m=5,+1,last) produces res_slots=1.
